reg_write_sched: RTL
====================

Name: reg_write_sched

Overview:
Clock-domain-side write scheduler for the I2C register interface. It converts the one-hot register-select strobe and received byte from the I2C receive front end into queued write transactions. It arbitrates those writes against a local (on-chip) write requester and drives a single-port 8-bit register bank through a wr_en/wr_ack handshake. Inputs sel_in/data_in are already synchronised to clk upstream.

Parameters:
NUM_REGS, 11, number of addressable registers (one-hot select width)
DATA_W, 8, register data width
FIFO_DEPTH, 2, depth of the I2C write queue (power of two)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
sel_in  in  NUM_REGS  register select from I2C front end, level, expected one-hot while active
data_in  in  DATA_W  received data byte, valid while sel_in != 0
loc_req  in  1  local write request, level, held until loc_gnt
loc_addr  in  4  local target register index
loc_data  in  DATA_W  local write data
loc_gnt  out  1  one-cycle pulse: local request completed (or rejected)
wr_en  out  1  register bank write strobe, held until wr_ack
wr_addr  out  4  register index for current write
wr_data  out  DATA_W  data for current write
wr_ack  in  1  register bank accepts write (may be same cycle as wr_en)
busy  out  1  high when state != IDLE or FIFO non-empty
err_sel  out  1  sticky: multi-hot sel_in event seen
err_ovf  out  1  sticky: I2C write dropped, FIFO full
err_addr  out  1  sticky: local address >= NUM_REGS
err_clr  in  1  clears all three sticky flags (set wins over clear in same cycle)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, FIFO empty, all outputs 0, sel_armed=0, last_src=LOC.
- Event detect: sel_armed <= (sel_in == 0). Event at edge when sel_in != 0 and sel_armed=1. A select held high through reset release produces no event until sel_in returns to 0.
- On event: exactly one bit i set -> push {addr=i, data=data_in}. Otherwise -> no push, err_sel<=1.
- Push when count==FIFO_DEPTH and no pop this edge -> drop, err_ovf<=1. Push plus pop on same edge when full -> accepted, count unchanged.
- FSM states IDLE, WR_I2C, WR_LOC. Exactly one write outstanding at a time.
- IDLE, arbitration per edge:
  - FIFO non-empty only -> WR_I2C.
  - loc_req only, loc_addr valid -> WR_LOC.
  - Both pending: winner is the source opposite last_src (round robin).
  - Entering WR_x registers wr_addr/wr_data and sets wr_en=1 from the next cycle.
- loc_req in IDLE with loc_addr >= NUM_REGS: rejected when local would win arbitration. loc_gnt pulse, err_addr<=1, no write, stay IDLE, last_src<=LOC.
- WR_x: wr_en, wr_addr and wr_data are held stable until an edge with wr_ack=1. On that edge:
  - wr_en<=0, state<=IDLE, last_src<=x.
  - WR_I2C: FIFO pop.
  - WR_LOC: loc_gnt=1 for the following cycle.
  - No back-to-back writes: at least one IDLE cycle between writes.
- wr_ack while IDLE is ignored.
- Latency: event sampled at edge k -> wr_en high after edge k+1 (FIFO empty, no contention). wr_ack at edge m -> wr_en low after m.
- FIFO order strictly FIFO. Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- Reset mid-write aborts: wr_en drops after the reset edge and queued entries are discarded.
- loc_req deasserted mid WR_LOC: write still completes and loc_gnt still pulses.

Test Plan:
- Reset then sel_in=0x010, data_in=0xA5, wr_ack tied 1 -> wr_en one cycle, wr_addr=4, wr_data=0xA5 two edges after event; busy returns 0.
- sel_in=0x003 event -> no write, err_sel=1; err_clr pulse -> err_sel=0.
- wr_ack held 0; three events (addr 1,2,3) -> writes 1,2 queued, event 3 dropped with err_ovf=1; release wr_ack -> writes addr 1 then 2, each separated by one IDLE cycle.
- FIFO holds addr 5 and loc_req (addr 7, 0x3C) pending in the same cycle -> I2C first (last_src=LOC at reset), then local; loc_gnt pulses once after its wr_ack.
- loc_req with loc_addr=12 -> loc_gnt pulse, err_addr=1, wr_en never asserted.
- rst_n low during WR_I2C with sel_in held 0x001 -> outputs 0, FIFO empty; no new write until sel_in returns to 0 and is re-asserted.

Source files
------------

// File: rtl/reg_write_sched.sv
// Write scheduler for the I2C register interface: queues one-hot select events,
// arbitrates them round-robin against a local requester and drives the register bank handshake.
module reg_write_sched #(
    parameter int NUM_REGS   = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REGS-1:0] sel_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                loc_req,
    input  logic [3:0]          loc_addr,
    input  logic [DATA_W-1:0]   loc_data,
    output logic                loc_gnt,
    output logic                wr_en,
    output logic [3:0]          wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                wr_ack,
    output logic                busy,
    output logic                err_sel,
    output logic                err_ovf,
    output logic                err_addr,
    input  logic                err_clr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR_I2C, WR_LOC} state_t;
    typedef enum logic {SRC_LOC, SRC_I2C} src_t;

    state_t state, state_nx;
    src_t   last_src, last_src_nx;

    logic                sel_armed;
    logic                sel_seen, sel_multi, sel_event;
    logic [3:0]          sel_idx;

    logic [3:0]          fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                fifo_ne, fifo_full, push_req, push_ok, pop;

    logic                loc_pend, pick_loc, loc_addr_bad;
    logic                wr_en_nx, loc_gnt_nx;
    logic [3:0]          wr_addr_nx;
    logic [DATA_W-1:0]   wr_data_nx;
    logic                set_sel, set_ovf, set_addr;

    always_comb begin
        sel_seen  = 1'b0;
        sel_multi = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_in[i]) begin
                if (sel_seen) sel_multi = 1'b1;
                sel_seen = 1'b1;
                sel_idx  = 4'(i);
            end
        end
    end

    assign sel_event    = sel_armed && (sel_in != '0);
    assign push_req     = sel_event && !sel_multi;
    assign set_sel      = sel_event && sel_multi;
    assign fifo_ne      = (count != '0);
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop          = (state == WR_I2C) && wr_ack;
    assign push_ok      = push_req && (!fifo_full || pop);
    assign set_ovf      = push_req && fifo_full && !pop;
    assign busy         = (state != IDLE) || fifo_ne;
    assign loc_addr_bad = ({1'b0, loc_addr} >= 5'(NUM_REGS));

    // A requester still looking at its grant pulse has already been served.
    assign loc_pend = loc_req && !loc_gnt;
    assign pick_loc = loc_pend && (!fifo_ne || last_src == SRC_I2C);

    always_comb begin
        state_nx    = state;
        last_src_nx = last_src;
        wr_en_nx    = wr_en;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        loc_gnt_nx  = 1'b0;
        set_addr    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_loc) begin
                    if (loc_addr_bad) begin
                        loc_gnt_nx  = 1'b1;
                        set_addr    = 1'b1;
                        last_src_nx = SRC_LOC;
                    end else begin
                        state_nx   = WR_LOC;
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = loc_addr;
                        wr_data_nx = loc_data;
                    end
                end else if (fifo_ne) begin
                    state_nx   = WR_I2C;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = fifo_addr[rd_ptr];
                    wr_data_nx = fifo_data[rd_ptr];
                end
            end
            WR_I2C: begin
                if (wr_ack) begin
                    state_nx    = IDLE;
                    wr_en_nx    = 1'b0;
                    last_src_nx = SRC_I2C;
                end
            end
            WR_LOC: begin
                if (wr_ack) begin
                    state_nx    = IDLE;
                    wr_en_nx    = 1'b0;
                    last_src_nx = SRC_LOC;
                    loc_gnt_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_src  <= SRC_LOC;
            sel_armed <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            loc_gnt   <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            err_sel   <= 1'b0;
            err_ovf   <= 1'b0;
            err_addr  <= 1'b0;
        end else begin
            state     <= state_nx;
            last_src  <= last_src_nx;
            sel_armed <= (sel_in == '0);
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            loc_gnt   <= loc_gnt_nx;
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            err_sel  <= set_sel  ? 1'b1 : (err_clr ? 1'b0 : err_sel);
            err_ovf  <= set_ovf  ? 1'b1 : (err_clr ? 1'b0 : err_ovf);
            err_addr <= set_addr ? 1'b1 : (err_clr ? 1'b0 : err_addr);
        end
    end

    // Queue storage needs no reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= sel_idx;
            fifo_data[wr_ptr] <= data_in;
        end
    end

endmodule
